// File: rtl/apb_master_fsm.sv
// ---------------------------------------------------------------------------
// apb_master_fsm
// APB master engine for the AHB-to-APB bridge. It accepts single-beat requests
// from the bridge control path, decodes the slave select from the address and
// runs the APB SETUP/ACCESS handshake. It handles PREADY wait states and
// PSLVERR, and returns one registered response pulse per request.
//
// Optional build macro: APB_TIMEOUT_EN
//   When defined, an ACCESS phase with PREADY held low is aborted with an
//   error response once TIMEOUT_CYCLES wait cycles have elapsed. When
//   undefined, ACCESS waits indefinitely.
//
// Ports
//   HCLK, HRESET        clock, synchronous active-high reset
//   REQ_VALID/READY     request handshake (READY combinational: IDLE, no reset)
//   REQ_WRITE/ADDR/WDATA request direction, address and write data
//   RSP_VALID           one-cycle response pulse, no back-pressure
//   RSP_RDATA, RSP_ERR  read data (0 for writes/errors), error flag
//   PADDR..PWDATA       registered APB master outputs
//   PRDATA/PREADY/PSLVERR APB slave inputs
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no transfer; accepts requests, decode misses answered here
// SETUP  | PSELX asserted, PENABLE low, one cycle
// ACCESS | PENABLE high, waiting for PREADY (or timeout abort)
// ---------------------------------------------------------------------------
module apb_master_fsm #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int SEL_LSB        = 28,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WRITE,
    input  logic [ADDR_W-1:0]     REQ_ADDR,
    input  logic [DATA_W-1:0]     REQ_WDATA,
    output logic                  RSP_VALID,
    output logic [DATA_W-1:0]     RSP_RDATA,
    output logic                  RSP_ERR,
    output logic [ADDR_W-1:0]     PADDR,
    output logic [NUM_SLAVES-1:0] PSELX,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_W-1:0]     PWDATA,
    input  logic [DATA_W-1:0]     PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int SEL_W = $clog2(NUM_SLAVES);
    localparam logic [SEL_W:0] NUM_SLAVES_L = (SEL_W + 1)'(NUM_SLAVES);

    if (NUM_SLAVES < 2) begin : g_bad_num_slaves
        $error("apb_master_fsm: NUM_SLAVES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 0) begin : g_bad_timeout
        $error("apb_master_fsm: TIMEOUT_CYCLES must be non-negative");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       paddr_q, paddr_d;
    logic [DATA_W-1:0]       pwdata_q, pwdata_d;
    logic                    pwrite_q, pwrite_d;
    logic                    penable_q, penable_d;
    logic [NUM_SLAVES-1:0]   psel_q, psel_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;

    logic [SEL_W-1:0]        idx;
    logic                    hit;
    logic                    accept;
    logic [NUM_SLAVES-1:0]   sel_dec;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_L = CNT_W'(TIMEOUT_CYCLES);
    logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
`endif

    assign REQ_READY = (state_q == IDLE) && !HRESET;
    assign accept    = REQ_VALID && REQ_READY;
    assign idx       = REQ_ADDR[SEL_LSB +: SEL_W];
    // Non-power-of-two slave counts leave index codes with no slave behind them.
    assign hit       = ({1'b0, idx} < NUM_SLAVES_L);

    always_comb begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_dec[i] = (idx == SEL_W'(i));
        end
    end

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        penable_d   = penable_q;
        psel_d      = psel_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    paddr_d  = REQ_ADDR;
                    pwdata_d = REQ_WDATA;
                    pwrite_d = REQ_WRITE;
                    if (hit) begin
                        state_d   = SETUP;
                        psel_d    = sel_dec;
                        penable_d = 1'b0;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    state_d     = IDLE;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PSLVERR;
                    rsp_rdata_d = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
                end
`ifdef APB_TIMEOUT_EN
                else if (wait_cnt_q == TIMEOUT_L) begin
                    state_d     = IDLE;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d   = IDLE;
                psel_d    = '0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            penable_q   <= 1'b0;
            psel_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            penable_q   <= penable_d;
            psel_q      <= psel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;
    assign PENABLE   = penable_q;
    assign PSELX     = psel_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_ERR   = rsp_err_q;
    assign RSP_RDATA = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_fsm.sv
// ---------------------------------------------------------------------------
// tb_apb_master_fsm
// Drives requests and emulates the APB slave; expected responses are queued
// when a request is issued and popped by an independent response monitor.
// NUM_SLAVES=3 so index 3 exercises the decode-miss path.
// ---------------------------------------------------------------------------
module tb_apb_master_fsm;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 3;
    localparam int SL = 28;
    localparam int TO = 4;

    logic           HCLK = 1'b0;
    logic           HRESET;
    logic           REQ_VALID;
    logic           REQ_READY;
    logic           REQ_WRITE;
    logic [AW-1:0]  REQ_ADDR;
    logic [DW-1:0]  REQ_WDATA;
    logic           RSP_VALID;
    logic [DW-1:0]  RSP_RDATA;
    logic           RSP_ERR;
    logic [AW-1:0]  PADDR;
    logic [NS-1:0]  PSELX;
    logic           PENABLE;
    logic           PWRITE;
    logic [DW-1:0]  PWDATA;
    logic [DW-1:0]  PRDATA;
    logic           PREADY;
    logic           PSLVERR;

    apb_master_fsm #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS), .SEL_LSB(SL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .PADDR(PADDR), .PSELX(PSELX), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    int unsigned cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int unsigned cyc;
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    logic [AW-1:0] last_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Response monitor: independent of the driver, consumes the expectation queue.
    always @(negedge HCLK) begin : monitor
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            tests++;
            fails++;
            $display("FAIL rsp_missing: no response seen, expected at cycle %0d (now %0d)", e.cyc, cyc);
        end
        if (RSP_VALID) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: RSP_VALID=1 with nothing outstanding (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                chk("rsp_err", 64'(RSP_ERR), 64'(e.err));
                chk("rsp_rdata", 64'(RSP_RDATA), 64'(e.rdata));
            end
        end
    end

    // One request from a negedge with the engine idle; returns at the negedge
    // of the response cycle (where the next request may already be issued).
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int waits, input logic [31:0] rd, input bit serr);
        int unsigned c;
        int          idx;
        bit          miss;
        bit          tmo;
        int          eff;
        exp_t        e;
        logic [NS-1:0] oh;
        idx  = int'(addr[SL +: 2]);
        miss = (idx >= NS);
        eff  = waits;
        tmo  = 1'b0;
`ifdef APB_TIMEOUT_EN
        if (waits > TO) begin
            eff = TO;
            tmo = 1'b1;
        end
`endif
        oh = '0;
        if (!miss) oh[idx] = 1'b1;
        c       = cyc;
        e.err   = miss || tmo || serr;
        e.rdata = (!wr && !e.err) ? rd : 32'h0;
        e.cyc   = miss ? c + 1 : c + 3 + eff;
        exp_q.push_back(e);
        last_addr = addr;

        chk("req_ready_idle", 64'(REQ_READY), 64'd1);
        REQ_VALID = 1'b1;
        REQ_WRITE = wr;
        REQ_ADDR  = addr;
        REQ_WDATA = wd;
        @(negedge HCLK);
        REQ_VALID = 1'b0;
        REQ_ADDR  = $urandom;
        REQ_WDATA = $urandom;
        REQ_WRITE = $urandom_range(0, 1);
        chk("paddr_latched", 64'(PADDR), 64'(addr));
        chk("pwrite_latched", 64'(PWRITE), 64'(wr));
        chk("pwdata_latched", 64'(PWDATA), 64'(wd));
        if (miss) begin
            chk("miss_psel", 64'(PSELX), 64'd0);
            chk("miss_ready", 64'(REQ_READY), 64'd1);
            return;
        end
        chk("setup_psel", 64'(PSELX), 64'(oh));
        chk("setup_penable", 64'(PENABLE), 64'd0);
        chk("setup_ready", 64'(REQ_READY), 64'd0);
        for (int k = 0; k <= eff; k++) begin
            @(negedge HCLK);
            chk("access_psel", 64'(PSELX), 64'(oh));
            chk("access_penable", 64'(PENABLE), 64'd1);
            chk("access_paddr", 64'(PADDR), 64'(addr));
            if (k < eff || tmo) begin
                PREADY  = 1'b0;
                PSLVERR = $urandom_range(0, 1);
                PRDATA  = $urandom;
            end else begin
                PREADY  = 1'b1;
                PSLVERR = serr;
                PRDATA  = serr ? 32'h0 : rd;
            end
        end
        @(negedge HCLK);
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = $urandom;
        chk("done_psel", 64'(PSELX), 64'd0);
        chk("done_penable", 64'(PENABLE), 64'd0);
        chk("done_ready", 64'(REQ_READY), 64'd1);
        chk("done_paddr_hold", 64'(PADDR), 64'(addr));
    endtask

    // Reset asserted while ACCESS is waiting: no response may follow.
    task automatic reset_mid();
        REQ_VALID = 1'b1;
        REQ_WRITE = 1'b0;
        REQ_ADDR  = 32'h1000_0020;
        REQ_WDATA = 32'h0;
        @(negedge HCLK);
        REQ_VALID = 1'b0;
        @(negedge HCLK);
        PREADY = 1'b0;
        chk("rst_pre_penable", 64'(PENABLE), 64'd1);
        HRESET = 1'b1;
        #1;
        chk("rst_ready_low", 64'(REQ_READY), 64'd0);
        @(negedge HCLK);
        chk("rst_psel", 64'(PSELX), 64'd0);
        chk("rst_penable", 64'(PENABLE), 64'd0);
        chk("rst_rsp_valid", 64'(RSP_VALID), 64'd0);
        chk("rst_ready_held", 64'(REQ_READY), 64'd0);
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("rst_ready_back", 64'(REQ_READY), 64'd1);
        chk("rst_no_rsp", 64'(RSP_VALID), 64'd0);
        last_addr = 32'h1000_0020;
    endtask

    initial begin : watchdog
        #(30000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [31:0] a;
        HRESET    = 1'b1;
        REQ_VALID = 1'b0;
        REQ_WRITE = 1'b0;
        REQ_ADDR  = '0;
        REQ_WDATA = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        last_addr = '0;
        repeat (3) @(negedge HCLK);
        chk("reset_ready", 64'(REQ_READY), 64'd0);
        chk("reset_psel", 64'(PSELX), 64'd0);
        chk("reset_penable", 64'(PENABLE), 64'd0);
        chk("reset_paddr", 64'(PADDR), 64'd0);
        chk("reset_pwdata", 64'(PWDATA), 64'd0);
        chk("reset_pwrite", 64'(PWRITE), 64'd0);
        chk("reset_rsp_valid", 64'(RSP_VALID), 64'd0);
        chk("reset_rsp_err", 64'(RSP_ERR), 64'd0);
        chk("reset_rsp_rdata", 64'(RSP_RDATA), 64'd0);
        HRESET = 1'b0;
        @(negedge HCLK);

        do_req(1'b1, 32'h1000_0040, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
        do_req(1'b0, 32'h2000_0004, 32'h0, 2, 32'h1234_5678, 1'b0);
        do_req(1'b0, 32'h0000_0010, 32'h0, 0, 32'hCAFE_F00D, 1'b1);
        do_req(1'b1, 32'h3000_0000, 32'h5555_AAAA, 0, 32'h0, 1'b0);
        do_req(1'b0, 32'h2000_0008, 32'h0, 1, 32'hA5A5_5A5A, 1'b0);
        reset_mid();
        do_req(1'b0, 32'h1000_0000, 32'h0, 0, 32'h0BAD_CAFE, 1'b0);
        do_req(1'b1, 32'h0000_0100, 32'h1357_9BDF, 100, 32'h0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge HCLK);
                REQ_ADDR = $urandom;
                chk("idle_paddr_hold", 64'(PADDR), 64'(last_addr));
            end
            a = $urandom;
            do_req(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 6),
                   $urandom, ($urandom_range(0, 3) == 0));
        end

        repeat (4) @(negedge HCLK);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
